eth_phy_10g_rx_block_sync: RTL and testbench



---
 rtl/eth_pcs_pkg.sv | 24 ++
 rtl/eth_phy_10g_rx_ber_mon.sv | 48 ++++
 rtl/eth_phy_10g_rx_block_sync.sv | 130 +++++++++++++
 tb/tb_eth_phy_10g_rx_block_sync.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/eth_pcs_pkg.sv
// Shared 10GBASE-R PCS definitions: sync header codes, block-sync states and default tunables.
package eth_pcs_pkg;

    localparam logic [1:0] SYNC_DATA = 2'b01;
    localparam logic [1:0] SYNC_CTRL = 2'b10;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        HOLDOFF  = 2'd1,
        LOCKED   = 2'd2
    } blk_sync_state_t;

    localparam int LOCK_COUNT_DEF   = 64;
    localparam int ERR_LIMIT_DEF    = 16;
    localparam int SLIP_HOLDOFF_DEF = 32;
    localparam int BER_WINDOW_DEF   = 19531;
    localparam int BER_LIMIT_DEF    = 16;
    localparam int ERR_COUNT_MAX    = 127;

    function automatic logic hdr_is_valid(input logic [1:0] hdr);
        return (hdr == SYNC_DATA) || (hdr == SYNC_CTRL);
    endfunction

endpackage

// File: rtl/eth_phy_10g_rx_ber_mon.sv
// BER monitor: free-running window, invalid-header count while locked, saturated
// per-window count and high-BER flag.
module eth_phy_10g_rx_ber_mon
    import eth_pcs_pkg::*;
#(
    parameter int BER_WINDOW = BER_WINDOW_DEF,
    parameter int BER_LIMIT  = BER_LIMIT_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       hdr_invalid,
    input  logic       lock,
    output logic       high_ber,
    output logic [6:0] error_count
);

    localparam int WIN_W = (BER_WINDOW > 1) ? $clog2(BER_WINDOW) : 1;

    logic [WIN_W-1:0] win_cnt;
    logic [6:0]       err_cnt;
    logic [7:0]       err_total;
    logic [6:0]       err_sat;
    logic             win_end;

    assign win_end   = (win_cnt == WIN_W'(BER_WINDOW - 1));
    assign err_total = {1'b0, err_cnt} + 8'(hdr_invalid & lock);
    assign err_sat   = (err_total > 8'(ERR_COUNT_MAX)) ? 7'(ERR_COUNT_MAX) : err_total[6:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt     <= '0;
            err_cnt     <= '0;
            high_ber    <= 1'b0;
            error_count <= '0;
        end else begin
            win_cnt <= win_end ? '0 : win_cnt + 1'b1;
            err_cnt <= win_end ? '0 : err_sat;
            // Published results only track while locked; an unlocked link reports no high BER.
            if (!lock) begin
                high_ber <= 1'b0;
            end else if (win_end) begin
                error_count <= err_sat;
                high_ber    <= (32'(err_sat) >= BER_LIMIT);
            end
        end
    end

endmodule

// File: rtl/eth_phy_10g_rx_block_sync.sv
// 64b/66b receive block synchroniser: block-lock FSM with gearbox slip control, plus BER monitor.
//   state    | meaning
//   UNLOCKED | counting consecutive valid headers; invalid header requests a slip
//   HOLDOFF  | gearbox settling after a slip; headers ignored
//   LOCKED   | monitoring sets of LOCK_COUNT headers for ERR_LIMIT invalid ones
module eth_phy_10g_rx_block_sync
    import eth_pcs_pkg::*;
#(
    parameter int LOCK_COUNT   = LOCK_COUNT_DEF,
    parameter int ERR_LIMIT    = ERR_LIMIT_DEF,
    parameter int SLIP_HOLDOFF = SLIP_HOLDOFF_DEF,
    parameter int BER_WINDOW   = BER_WINDOW_DEF,
    parameter int BER_LIMIT    = BER_LIMIT_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] rx_hdr,
    input  logic       rx_hdr_valid,
    output logic       rx_bitslip,
    output logic       rx_block_lock,
    output logic       rx_high_ber,
    output logic [6:0] rx_error_count
);

    localparam int SH_W   = $clog2(LOCK_COUNT + 1);
    localparam int INV_W  = $clog2(ERR_LIMIT + 1);
    localparam int HOLD_W = (SLIP_HOLDOFF > 1) ? $clog2(SLIP_HOLDOFF) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(SLIP_HOLDOFF - 1);

    blk_sync_state_t   state, state_nxt;
    logic [SH_W-1:0]   sh_cnt, sh_nxt, sh_inc;
    logic [INV_W-1:0]  inv_cnt, inv_nxt, inv_inc;
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;
    logic              slip_nxt;
    logic              hdr_good, hdr_bad;

    assign hdr_good = rx_hdr_valid & hdr_is_valid(rx_hdr);
    assign hdr_bad  = rx_hdr_valid & ~hdr_is_valid(rx_hdr);
    assign sh_inc   = sh_cnt + 1'b1;
    assign inv_inc  = inv_cnt + INV_W'(hdr_bad);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= UNLOCKED;
            sh_cnt     <= '0;
            inv_cnt    <= '0;
            hold_cnt   <= '0;
            rx_bitslip <= 1'b0;
        end else begin
            state      <= state_nxt;
            sh_cnt     <= sh_nxt;
            inv_cnt    <= inv_nxt;
            hold_cnt   <= hold_nxt;
            rx_bitslip <= slip_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        sh_nxt    = sh_cnt;
        inv_nxt   = inv_cnt;
        hold_nxt  = hold_cnt;
        slip_nxt  = 1'b0;
        unique case (state)
            UNLOCKED: begin
                if (hdr_bad) begin
                    slip_nxt  = 1'b1;
                    sh_nxt    = '0;
                    inv_nxt   = '0;
                    hold_nxt  = HOLD_LOAD;
                    state_nxt = HOLDOFF;
                end else if (hdr_good) begin
                    if (sh_inc == SH_W'(LOCK_COUNT)) begin
                        sh_nxt    = '0;
                        inv_nxt   = '0;
                        state_nxt = LOCKED;
                    end else begin
                        sh_nxt = sh_inc;
                    end
                end
            end
            HOLDOFF: begin
                if (hold_cnt == '0) begin
                    state_nxt = UNLOCKED;
                end else begin
                    hold_nxt = hold_cnt - 1'b1;
                end
            end
            LOCKED: begin
                // Error limit is tested first so it wins on the last header of a set.
                if (rx_hdr_valid) begin
                    if (inv_inc == INV_W'(ERR_LIMIT)) begin
                        slip_nxt  = 1'b1;
                        sh_nxt    = '0;
                        inv_nxt   = '0;
                        hold_nxt  = HOLD_LOAD;
                        state_nxt = HOLDOFF;
                    end else if (sh_inc == SH_W'(LOCK_COUNT)) begin
                        sh_nxt  = '0;
                        inv_nxt = '0;
                    end else begin
                        sh_nxt  = sh_inc;
                        inv_nxt = inv_inc;
                    end
                end
            end
            default: begin
                state_nxt = UNLOCKED;
                sh_nxt    = '0;
                inv_nxt   = '0;
                hold_nxt  = '0;
            end
        endcase
    end

    assign rx_block_lock = (state == LOCKED);

    eth_phy_10g_rx_ber_mon #(
        .BER_WINDOW (BER_WINDOW),
        .BER_LIMIT  (BER_LIMIT)
    ) u_ber_mon (
        .clk         (clk),
        .rst_n       (rst_n),
        .hdr_invalid (hdr_bad),
        .lock        (rx_block_lock),
        .high_ber    (rx_high_ber),
        .error_count (rx_error_count)
    );

endmodule

// File: tb/tb_eth_phy_10g_rx_block_sync.sv
// Directed bench for the block synchroniser; BER window shortened to 128 cycles.
module tb_eth_phy_10g_rx_block_sync;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] rx_hdr;
    logic       rx_hdr_valid;
    logic       rx_bitslip;
    logic       rx_block_lock;
    logic       rx_high_ber;
    logic [6:0] rx_error_count;

    int n_vec    = 0;
    int n_err    = 0;
    int slip_cnt = 0;

    eth_phy_10g_rx_block_sync #(
        .BER_WINDOW (128)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rx_hdr         (rx_hdr),
        .rx_hdr_valid   (rx_hdr_valid),
        .rx_bitslip     (rx_bitslip),
        .rx_block_lock  (rx_block_lock),
        .rx_high_ber    (rx_high_ber),
        .rx_error_count (rx_error_count)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk7(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One header per clock edge; outputs are sampled 1 ns after that edge.
    task automatic step(input logic [1:0] h, input logic v);
        rx_hdr       = h;
        rx_hdr_valid = v;
        @(posedge clk);
        #1;
        slip_cnt += int'(rx_bitslip);
    endtask

    task automatic run(input logic [1:0] h, input int n);
        repeat (n) step(h, 1'b1);
    endtask

    task automatic do_reset();
        rx_hdr       = 2'b00;
        rx_hdr_valid = 1'b0;
        rst_n        = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n    = 1'b1;
        slip_cnt = 0;
    endtask

    task automatic window_with_errors();
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 64; i++)
                step((i < 60 && i % 6 == 0) ? 2'b11 : 2'b01, 1'b1);
    endtask

    initial begin
        do_reset();
        chk1("rst_lock", rx_block_lock, 1'b0);
        chk1("rst_slip", rx_bitslip, 1'b0);
        chk1("rst_high_ber", rx_high_ber, 1'b0);
        chk7("rst_err_count", rx_error_count, 7'd0);

        // Acquire lock on 64 clean headers
        run(2'b01, 63);
        chk1("acq_pre_lock", rx_block_lock, 1'b0);
        step(2'b01, 1'b1);
        chk1("acq_lock", rx_block_lock, 1'b1);
        chkn("acq_no_slip", slip_cnt, 0);

        // Slip and holdoff
        do_reset();
        run(2'b10, 9);
        chk1("slip_none_yet", rx_bitslip, 1'b0);
        step(2'b00, 1'b1);
        chk1("slip_first", rx_bitslip, 1'b1);
        slip_cnt = 0;
        step(2'b00, 1'b1);
        chk1("slip_single_cycle", rx_bitslip, 1'b0);
        run(2'b00, 31);
        chkn("slip_holdoff_quiet", slip_cnt, 0);
        step(2'b00, 1'b1);
        chk1("slip_second", rx_bitslip, 1'b1);

        // Locked error sets
        do_reset();
        run(2'b01, 64);
        chk1("set_locked", rx_block_lock, 1'b1);
        slip_cnt = 0;
        for (int i = 0; i < 64; i++) step((i < 60 && i % 4 == 0) ? 2'b11 : 2'b01, 1'b1);
        chk1("set15_keep_lock", rx_block_lock, 1'b1);
        chkn("set15_no_slip", slip_cnt, 0);
        for (int i = 0; i < 39; i++) step((i < 30 && i % 2 == 0) ? 2'b11 : 2'b01, 1'b1);
        chk1("set16_pre_lock", rx_block_lock, 1'b1);
        step(2'b11, 1'b1);
        chk1("set16_lose_lock", rx_block_lock, 1'b0);
        chk1("set16_slip", rx_bitslip, 1'b1);

        // Unevaluated invalid headers are ignored
        do_reset();
        run(2'b01, 30);
        for (int i = 0; i < 33; i++) begin
            step(2'b00, 1'b0);
            step(2'b01, 1'b1);
        end
        step(2'b00, 1'b0);
        chk1("gap_pre_lock", rx_block_lock, 1'b0);
        step(2'b01, 1'b1);
        chk1("gap_lock", rx_block_lock, 1'b1);
        chkn("gap_no_slip", slip_cnt, 0);

        // BER monitor: edges counted from reset release, window closes on every 128th edge
        do_reset();
        run(2'b01, 128);
        chk1("ber_w0_lock", rx_block_lock, 1'b1);
        chk7("ber_w0_count", rx_error_count, 7'd0);
        chk1("ber_w0_high", rx_high_ber, 1'b0);
        window_with_errors();
        chk7("ber_w1_count", rx_error_count, 7'd20);
        chk1("ber_w1_high", rx_high_ber, 1'b1);
        chk1("ber_w1_lock", rx_block_lock, 1'b1);
        run(2'b01, 128);
        chk7("ber_w2_count", rx_error_count, 7'd0);
        chk1("ber_w2_high", rx_high_ber, 1'b0);
        window_with_errors();
        chk7("ber_w3_count", rx_error_count, 7'd20);
        chk1("ber_w3_high", rx_high_ber, 1'b1);

        // Asynchronous reset mid-cycle while locked
        run(2'b01, 10);
        #2;
        rst_n = 1'b0;
        #1;
        chk1("arst_lock", rx_block_lock, 1'b0);
        chk1("arst_high", rx_high_ber, 1'b0);
        chk7("arst_count", rx_error_count, 7'd0);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        slip_cnt = 0;
        run(2'b01, 63);
        chk1("relock_pre", rx_block_lock, 1'b0);
        step(2'b01, 1'b1);
        chk1("relock", rx_block_lock, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
